// File: rtl/uart_prog_loader_pkg.sv
// Shared types and default constants for the UART program loader.
// Latency: n/a (types only).
// Backpressure: n/a.
package uart_loader_pkg;

   localparam int CLKS_PER_BIT_DEF = 434;      // 50 MHz / 115200 baud
   localparam int MAX_WORDS_DEF    = 1024;
   localparam int TIMEOUT_CLKS_DEF = 5000000;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      L_IDLE,
      L_LEN,
      L_DATA,
      L_WRITE,
      L_DONE
   } ld_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte stream from the serial receiver to the loader FSM.
// Latency: n/a (wires only); byte_valid and frame_err are single-cycle pulses.
// Backpressure: none, the consumer must take every pulse.
// master: receiver drives byte_valid, byte_data[7:0], frame_err; slave: loader observes them.
interface uart_prog_loader_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_err;

   modport master (output byte_valid, byte_data, frame_err);
   modport slave  (input  byte_valid, byte_data, frame_err);
endinterface

// File: rtl/uart_prog_loader_rx.sv
// 8N1 serial receiver with 2-flop input synchronizer and false-start rejection.
// Latency: byte_valid/frame_err pulse 1 cycle after the stop-bit centre sample.
// Backpressure: none; returns to RX_IDLE on the stop sample so frames can be back-to-back.
// Ports: clk, rst_n (async low), rx_i (serial line, idle high), byte_if (master: byte stream out).
module uart_rx
   import uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                rx_i,
   uart_prog_loader_if.master  byte_if
);

   localparam int             CW      = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic [1:0]    sync_q;
   logic          rx_prev_q;
   rx_state_t     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          byte_valid_q;
   logic          frame_err_q;
   logic          rx_s;

   assign rx_s               = sync_q[1];
   assign byte_if.byte_valid = byte_valid_q;
   assign byte_if.byte_data  = shift_q;
   assign byte_if.frame_err  = frame_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q       <= 2'b11;
         rx_prev_q    <= 1'b1;
         state_q      <= RX_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], rx_i};
         rx_prev_q    <= rx_s;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               // Start only on a genuine high-to-low edge, not a line held low.
               if (rx_prev_q && !rx_s) begin
                  state_q <= RX_START;
                  cnt_q   <= '0;
               end
            end
            RX_START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q <= '0;
                  bit_q <= '0;
                  // Line back high at mid-start-bit means a glitch.
                  state_q <= rx_s ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_s, shift_q[7:1]};
                  bit_q   <= bit_q + 1'b1;
                  if (bit_q == 3'd7) state_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q        <= '0;
                  byte_valid_q <= rx_s;
                  frame_err_q  <= !rx_s;
                  state_q      <= RX_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: receives a LE word count then LE words, writes them to IRAM from address 0.
// Latency: prog_we asserts 2 cycles after the stop sample of each word's 4th byte.
// Backpressure: none; IRAM must accept one write per prog_we cycle.
// Ports: clk, Rst (async low), uart_rx (serial in); prog_ena/prog_we/prog_addr/prog_din to IRAM;
//        load_done (1-cycle pulse on success), load_err (sticky until next load starts).
module uart_prog_loader
   import uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int MAX_WORDS    = MAX_WORDS_DEF,
   parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
   input  logic        clk,
   input  logic        Rst,
   input  logic        uart_rx,
   output logic        prog_ena,
   output logic        prog_we,
   output logic [31:0] prog_addr,
   output logic [31:0] prog_din,
   output logic        load_done,
   output logic        load_err
);

   localparam logic [31:0] MAX_W  = 32'(MAX_WORDS);
   localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CLKS - 1);

   // Assert asynchronously, release synchronously so no flop sees a
   // reset edge close to a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) rst_sync_q <= 2'b00;
      else      rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   uart_prog_loader_if rx_bus ();

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx_i    (uart_rx),
      .byte_if (rx_bus.master)
   );

   ld_state_t   state_q;
   logic [1:0]  byte_cnt_q;
   logic [31:0] len_q;
   logic [31:0] len_d;
   logic [31:0] word_cnt_q;
   logic [31:0] to_cnt_q;
   logic [31:0] prog_addr_q;
   logic [31:0] prog_din_q;
   logic        prog_ena_q;
   logic        prog_we_q;
   logic        load_done_q;
   logic        load_err_q;

   // Length arrives LSB first; shifting each byte in from the top leaves
   // byte 0 in [7:0] after the fourth byte.
   always_comb begin
      len_d = {rx_bus.byte_data, len_q[31:8]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= L_IDLE;
         byte_cnt_q  <= '0;
         len_q       <= '0;
         word_cnt_q  <= '0;
         to_cnt_q    <= '0;
         prog_addr_q <= '0;
         prog_din_q  <= '0;
         prog_ena_q  <= 1'b0;
         prog_we_q   <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         prog_we_q   <= 1'b0;
         load_done_q <= 1'b0;

         if (rx_bus.byte_valid || state_q == L_IDLE || state_q == L_DONE)
            to_cnt_q <= '0;
         else
            to_cnt_q <= to_cnt_q + 32'd1;

         case (state_q)
            L_IDLE: begin
               if (rx_bus.byte_valid) begin
                  state_q     <= L_LEN;
                  prog_ena_q  <= 1'b1;
                  load_err_q  <= 1'b0;
                  len_q       <= {rx_bus.byte_data, 24'h0};
                  byte_cnt_q  <= 2'd1;
                  word_cnt_q  <= '0;
                  prog_addr_q <= '0;
               end
            end
            L_LEN, L_DATA: begin
               if (rx_bus.byte_valid) begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (state_q == L_LEN) begin
                     len_q <= len_d;
                     if (byte_cnt_q == 2'd3) begin
                        if (len_d == 32'd0) begin
                           state_q     <= L_DONE;
                           load_done_q <= 1'b1;
                           prog_ena_q  <= 1'b0;
                        end else if (len_d > MAX_W) begin
                           state_q    <= L_IDLE;
                           load_err_q <= 1'b1;
                           prog_ena_q <= 1'b0;
                        end else begin
                           state_q <= L_DATA;
                        end
                     end
                  end else begin
                     prog_din_q <= {rx_bus.byte_data, prog_din_q[31:8]};
                     if (byte_cnt_q == 2'd3) begin
                        state_q   <= L_WRITE;
                        prog_we_q <= 1'b1;
                     end
                  end
               end else if (rx_bus.frame_err || to_cnt_q >= TO_LIM) begin
                  // Abandon the load; any partial word is simply dropped.
                  state_q    <= L_IDLE;
                  load_err_q <= 1'b1;
                  prog_ena_q <= 1'b0;
                  byte_cnt_q <= '0;
               end
            end
            L_WRITE: begin
               prog_addr_q <= prog_addr_q + 32'd4;
               word_cnt_q  <= word_cnt_q + 32'd1;
               if (word_cnt_q + 32'd1 == len_q) begin
                  state_q     <= L_DONE;
                  load_done_q <= 1'b1;
                  prog_ena_q  <= 1'b0;
               end else begin
                  state_q <= L_DATA;
               end
            end
            L_DONE: begin
               state_q     <= L_IDLE;
               prog_addr_q <= '0;
               word_cnt_q  <= '0;
               byte_cnt_q  <= '0;
            end
            default: state_q <= L_IDLE;
         endcase
      end
   end

   assign prog_ena  = prog_ena_q;
   assign prog_we   = prog_we_q;
   assign prog_addr = prog_addr_q;
   assign prog_din  = prog_din_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: serialises load images and checks the IRAM write stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_prog_loader;
   import uart_loader_pkg::*;

   localparam int CPB  = 16;
   localparam int TO   = 2000;
   localparam int MAXW = 1024;

   logic        clk     = 1'b0;
   logic        Rst     = 1'b0;
   logic        rx_line = 1'b1;
   logic        prog_ena, prog_we, load_done, load_err;
   logic [31:0] prog_addr, prog_din;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW), .TIMEOUT_CLKS(TO)) dut (
      .clk       (clk),
      .Rst       (Rst),
      .uart_rx   (rx_line),
      .prog_ena  (prog_ena),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_din  (prog_din),
      .load_done (load_done),
      .load_err  (load_err)
   );

   // Standalone receiver on the same line, used to observe raw byte events.
   uart_prog_loader_if mon_if ();
   uart_rx #(.CLKS_PER_BIT(CPB)) u_mon (
      .clk     (clk),
      .rst_n   (Rst),
      .rx_i    (rx_line),
      .byte_if (mon_if.master)
   );

   logic [31:0] wr_addr[$];
   logic [31:0] wr_din[$];
   int          done_cnt  = 0;
   int          we_long   = 0;
   int          mon_bytes = 0;
   logic        we_prev   = 1'b0;

   always @(negedge clk) begin
      if (prog_we) begin
         wr_addr.push_back(prog_addr);
         wr_din.push_back(prog_din);
         if (we_prev) we_long++;
      end
      we_prev = prog_we;
      if (load_done) done_cnt++;
      if (mon_if.byte_valid) mon_bytes++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk);
      wr_addr.delete();
      wr_din.delete();
      done_cnt  = 0;
      we_long   = 0;
      mon_bytes = 0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_line = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx_line = stop_bit;
      repeat (CPB) @(negedge clk);
      rx_line = 1'b1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
   endtask

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
      return (q.size() > idx) ? q[idx] : 32'hxxxx_xxxx;
   endfunction

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check_eq("rst_ena",  32'(prog_ena),  32'd0);
      check_eq("rst_we",   32'(prog_we),   32'd0);
      check_eq("rst_addr", prog_addr,      32'd0);
      check_eq("rst_din",  prog_din,       32'd0);
      check_eq("rst_done", 32'(load_done), 32'd0);
      check_eq("rst_err",  32'(load_err),  32'd0);
      Rst = 1'b1;
      repeat (5) @(negedge clk);

      // Two-word load
      clear_mon();
      send_word(32'd2);
      check_eq("t1_ena_mid", 32'(prog_ena), 32'd1);
      send_word(32'hDEAD_BEEF);
      send_word(32'h0000_0013);
      repeat (20) @(negedge clk);
      check_eq("t1_nwr",   32'(wr_addr.size()), 32'd2);
      check_eq("t1_addr0", q_at(wr_addr, 0), 32'h0);
      check_eq("t1_din0",  q_at(wr_din, 0),  32'hDEAD_BEEF);
      check_eq("t1_addr1", q_at(wr_addr, 1), 32'h4);
      check_eq("t1_din1",  q_at(wr_din, 1),  32'h0000_0013);
      check_eq("t1_welen", 32'(we_long),  32'd0);
      check_eq("t1_done",  32'(done_cnt), 32'd1);
      check_eq("t1_ena",   32'(prog_ena), 32'd0);
      check_eq("t1_err",   32'(load_err), 32'd0);

      // Empty image
      clear_mon();
      send_word(32'd0);
      repeat (20) @(negedge clk);
      check_eq("t2_nwr",  32'(wr_addr.size()), 32'd0);
      check_eq("t2_done", 32'(done_cnt), 32'd1);
      check_eq("t2_err",  32'(load_err), 32'd0);

      // Oversize image, then a valid reload
      clear_mon();
      send_word(32'(MAXW + 1));
      repeat (20) @(negedge clk);
      check_eq("t3_err",  32'(load_err), 32'd1);
      check_eq("t3_nwr",  32'(wr_addr.size()), 32'd0);
      check_eq("t3_done", 32'(done_cnt), 32'd0);
      check_eq("t3_ena",  32'(prog_ena), 32'd0);
      send_byte(8'h01, 1'b1);
      repeat (4) @(negedge clk);
      check_eq("t3_errclr", 32'(load_err), 32'd0);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_word(32'h1234_5678);
      repeat (20) @(negedge clk);
      check_eq("t3_nwr2",  32'(wr_addr.size()), 32'd1);
      check_eq("t3_addr",  q_at(wr_addr, 0), 32'h0);
      check_eq("t3_din",   q_at(wr_din, 0),  32'h1234_5678);
      check_eq("t3_done2", 32'(done_cnt), 32'd1);

      // Framing error on the third data byte, then a one-cycle glitch
      clear_mon();
      send_word(32'd1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b0);
      repeat (10) @(negedge clk);
      check_eq("t4_err",   32'(load_err), 32'd1);
      check_eq("t4_nwr",   32'(wr_addr.size()), 32'd0);
      check_eq("t4_ena",   32'(prog_ena), 32'd0);
      check_eq("t4_state", 32'(dut.state_q), 32'(L_IDLE));
      clear_mon();
      rx_line = 1'b0;
      @(negedge clk);
      rx_line = 1'b1;
      repeat (60) @(negedge clk);
      check_eq("t4_glitch_bytes", 32'(mon_bytes), 32'd0);
      check_eq("t4_glitch_state", 32'(dut.state_q), 32'(L_IDLE));
      check_eq("t4_glitch_err",   32'(load_err), 32'd1);

      // Inter-byte timeout
      clear_mon();
      send_word(32'd1);
      check_eq("t5_err_clr", 32'(load_err), 32'd0);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      repeat (TO + 50) @(negedge clk);
      check_eq("t5_err", 32'(load_err), 32'd1);
      check_eq("t5_ena", 32'(prog_ena), 32'd0);
      check_eq("t5_nwr", 32'(wr_addr.size()), 32'd0);

      // Reset in the middle of a data word
      clear_mon();
      send_word(32'd2);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      check_eq("t6_ena_pre", 32'(prog_ena), 32'd1);
      Rst = 1'b0;
      #1;
      check_eq("t6_ena",  32'(prog_ena),  32'd0);
      check_eq("t6_we",   32'(prog_we),   32'd0);
      check_eq("t6_addr", prog_addr,      32'd0);
      check_eq("t6_din",  prog_din,       32'd0);
      check_eq("t6_done", 32'(load_done), 32'd0);
      check_eq("t6_err",  32'(load_err),  32'd0);
      repeat (3) @(negedge clk);
      Rst = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("t6_nwr_rst", 32'(wr_addr.size()), 32'd0);
      send_word(32'd1);
      send_word(32'hCAFE_F00D);
      repeat (20) @(negedge clk);
      check_eq("t6_nwr",  32'(wr_addr.size()), 32'd1);
      check_eq("t6_addr0", q_at(wr_addr, 0), 32'h0);
      check_eq("t6_din0",  q_at(wr_din, 0),  32'hCAFE_F00D);
      check_eq("t6_done1", 32'(done_cnt), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 SHALL have parameter MAX_WORDS, default 1024, meaning the largest program (in 32-bit words) accepted.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 5000000, meaning the maximum idle gap between bytes mid-load.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port Rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port uart_rx, input, 1 bit: serial line, idle high, 8N1, LSB first.
REQ-007 SHALL have port prog_ena, output, 1 bit: drives IRAM controller program-load enable.
REQ-008 SHALL have port prog_we, output, 1 bit: one-cycle word write strobe to IRAM.
REQ-009 SHALL have port prog_addr, output, 32 bits: byte address of the word being written.
REQ-010 SHALL have port prog_din, output, 32 bits: word data to IRAM.
REQ-011 SHALL have port load_done, output, 1 bit: one-cycle pulse on successful completion.
REQ-012 SHALL have port load_err, output, 1 bit: sticky error flag.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer, with both flops reset to 1.
REQ-014 Receiver start bit: a falling edge in RX_IDLE SHALL start a count; the line SHALL be sampled at CLKS_PER_BIT/2; if it is high, it is a false start and the receiver SHALL return to RX_IDLE.
REQ-015 Receiver data bits: the receiver SHALL sample 8 data bits at bit centres, every CLKS_PER_BIT cycles, LSB first.
REQ-016 Receiver stop bit: the stop-bit sample SHALL be taken at its centre; high SHALL produce a one-cycle byte_valid; low SHALL produce a one-cycle frame_err and no byte.
REQ-017 After the stop-bit sample, the receiver SHALL return to RX_IDLE in the same cycle, so back-to-back frames are accepted.
REQ-018 Protocol: the frame SHALL be a 4-byte little-endian word count N, then N words, each 4 bytes little-endian.
REQ-019 Loader FSM states SHALL be L_IDLE, L_LEN, L_DATA, L_WRITE and L_DONE.
REQ-020 L_IDLE SHALL go to L_LEN on the first byte; that byte is LEN[7:0].
REQ-021 L_LEN SHALL collect the remaining 3 length bytes using a byte counter 0..3 that wraps to 0.
REQ-022 When the length is complete: N=0 SHALL go to L_DONE; N>MAX_WORDS SHALL set load_err and go to L_IDLE with no write; otherwise the FSM SHALL go to L_DATA.
REQ-023 L_DATA SHALL assemble 4 bytes into prog_din, byte k into bits [8k+7:8k], then go to L_WRITE.
REQ-024 L_WRITE SHALL assert prog_we for exactly one cycle, then add 4 to prog_addr and increment the word count.
REQ-025 After L_WRITE, the FSM SHALL go to L_DONE if word count equals N, else back to L_DATA.
REQ-026 The first write SHALL use prog_addr = 0; writes SHALL be sequential with no gaps or repeats.
REQ-027 prog_ena SHALL be 1 in L_LEN, L_DATA and L_WRITE, and 0 otherwise.
REQ-028 prog_addr and prog_din SHALL be stable while prog_we is 1.
REQ-029 L_DONE SHALL pulse load_done for one cycle, clear prog_addr and the counters, and go to L_IDLE.
REQ-030 frame_err in L_LEN or L_DATA SHALL set load_err and go to L_IDLE; partial words are discarded.
REQ-031 Timeout: a counter SHALL clear on every byte_valid; reaching TIMEOUT_CLKS in L_LEN or L_DATA SHALL set load_err and go to L_IDLE.
REQ-032 load_err SHALL clear only on the next L_IDLE to L_LEN transition, or on reset.
REQ-033 A byte arriving during L_WRITE is impossible, since a frame lasts 10×CLKS_PER_BIT; no buffering is required.
REQ-034 A 32-bit N SHALL be compared unsigned; prog_addr arithmetic SHALL wrap modulo 2^32.

Reset
REQ-035 Asserting Rst low at any time SHALL force RX_IDLE and L_IDLE, abandoning any load in progress with no further writes.
REQ-036 Reset values: prog_ena=0, prog_we=0, prog_addr=0, prog_din=0, load_done=0, load_err=0, and all counters 0.
REQ-037 Reset release SHALL be synchronized to clk; the first FSM action occurs no earlier than 2 cycles after deassertion.

Structure
REQ-038 Package uart_loader_pkg SHALL hold the rx_state_t and ld_state_t enums and the default constants for CLKS_PER_BIT, MAX_WORDS and TIMEOUT_CLKS.
REQ-039 The serial receiver SHALL be a separate sub-module, uart_rx, with outputs byte_valid, byte_data[7:0] and frame_err; the loader FSM lives in the top module.

Verification (CLKS_PER_BIT=16, TIMEOUT_CLKS=2000)
REQ-040 Send N=2, words 0xDEADBEEF and 0x00000013 -> writes (0x0, 0xDEADBEEF) then (0x4, 0x00000013), each prog_we one cycle, load_done pulses once, prog_ena low afterwards.
REQ-041 Send N=0 -> no prog_we, load_done pulses, load_err=0.
REQ-042 Send N=MAX_WORDS+1 -> load_err=1, no prog_we; a following valid N=1 load clears load_err and writes.
REQ-043 Give the 3rd data byte a stop bit of 0 -> load_err=1, no write of that word, FSM in L_IDLE; a 1-cycle-low glitch produces no byte.
REQ-044 Stall 2000 cycles after 2 data bytes -> load_err=1, prog_ena=0.
REQ-045 Assert Rst mid-L_DATA -> all outputs at reset values immediately; a reload after release starts at prog_addr=0.
